// File: rtl/regfile_multiport.sv
// Multi-port register file: byte-enable writes, optional write-to-read forwarding,
// write freeze, and a post-reset sweep that loads every register with a known value.

module regfile_rd_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic              busy,
  input  logic              commit,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] merged,
  input  logic [DATA_W-1:0] rf_q,
  output logic [DATA_W-1:0] rd
);
  always_comb begin
    rd = rf_q;
    if (busy)
      rd = '0;
    else if ((ZERO_R0 != 0) && (ra == '0))
      rd = '0;
    else if ((BYPASS != 0) && commit && (ra == wa))
      rd = merged;
  end
endmodule

module regfile_multiport #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NRD       = 2,
  parameter int ZERO_R0   = 1,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  wfreeze,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [ADDR_W-1:0]     wa,
  input  logic [DATA_W-1:0]     wd,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic                  busy,
  output logic                  sweep_done
);
  localparam int NREGS = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] rf [NREGS];
  logic [DATA_W-1:0] init_val;
  logic [DATA_W-1:0] merged;
  logic              commit;

  // Sweep FSM: one register per cycle, last index hands over to READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      ptr        <= '0;
      busy       <= 1'b1;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (&ptr) begin
            state      <= READY;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
          end
        end
        default: state <= READY;
      endcase
    end
  end

  assign init_val = (INIT_MODE != 0) ? DATA_W'(ptr) : '0;

  assign commit = !rst && (state == READY) && we && !wfreeze && (|wbe) &&
                  !((ZERO_R0 != 0) && (wa == '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        rf[ptr] <= init_val;
      else if (commit)
        for (int k = 0; k < NB; k++)
          if (wbe[k]) rf[wa][8*k +: 8] <= wd[8*k +: 8];
    end
  end

  // Word as it will look after this cycle's write; forwarded on an address hit.
  always_comb begin
    merged = rf[wa];
    for (int k = 0; k < NB; k++)
      if (wbe[k]) merged[8*k +: 8] = wd[8*k +: 8];
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra_p;
    assign ra_p = ra[p*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0),
      .BYPASS (BYPASS)
    ) u_rd (
      .busy  (busy),
      .commit(commit),
      .ra    (ra_p),
      .wa    (wa),
      .merged(merged),
      .rf_q  (rf[ra_p]),
      .rd    (rd[p*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: three variants (default, no forwarding, zero-init)
// driven with shared stimulus and checked against an array-based reference model.

module tb_regfile_multiport;
  logic        clk = 1'b0;
  logic        rst = 1'b0, we = 1'b0, wfreeze = 1'b0;
  logic [3:0]  wbe = '0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [9:0]  ra = '0;
  logic [63:0] rd_a, rd_b, rd_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;

  always #5 clk = ~clk;

  regfile_multiport u_a (
    .clk(clk), .rst(rst), .we(we), .wfreeze(wfreeze), .wbe(wbe), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd_a), .busy(busy_a), .sweep_done(done_a));

  regfile_multiport #(.BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .we(we), .wfreeze(wfreeze), .wbe(wbe), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd_b), .busy(busy_b), .sweep_done(done_b));

  regfile_multiport #(.INIT_MODE(0)) u_c (
    .clk(clk), .rst(rst), .we(we), .wfreeze(wfreeze), .wbe(wbe), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd_c), .busy(busy_c), .sweep_done(done_c));

  int n_cmp = 0, n_bad = 0;
  int busy_cnt = 0, done_cnt = 0;

  // Reference model: one array per variant, plus sweep progress.
  logic [31:0] mem [3][32];
  bit          mbusy = 1'b1, mdone = 1'b0, mvalid = 1'b0;
  int          mptr = 0;
  logic [63:0] obs_rd [3];
  logic        obs_busy [3], obs_done [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_commit();
    return !rst && !mbusy && we && !wfreeze && (wbe != 4'h0) && (wa != 5'd0);
  endfunction

  function automatic logic [31:0] after_write(input int d);
    logic [31:0] m;
    m = mem[d][wa];
    for (int k = 0; k < 4; k++)
      if (wbe[k]) m[8*k +: 8] = wd[8*k +: 8];
    return m;
  endfunction

  function automatic logic [31:0] exp_rd(input int d, input logic [4:0] a);
    if (mbusy || a == 5'd0) return 32'h0;
    if (d != 1 && model_commit() && a == wa) return after_write(d);
    return mem[d][a];
  endfunction

  task automatic cyc(input bit r, input bit w, input bit f, input logic [3:0] be,
                     input logic [4:0] a, input logic [31:0] d,
                     input logic [4:0] r0, input logic [4:0] r1);
    @(negedge clk);
    rst = r; we = w; wfreeze = f; wbe = be; wa = a; wd = d; ra = {r1, r0};
    #1;
    obs_rd[0] = rd_a;   obs_rd[1] = rd_b;   obs_rd[2] = rd_c;
    obs_busy[0] = busy_a; obs_busy[1] = busy_b; obs_busy[2] = busy_c;
    obs_done[0] = done_a; obs_done[1] = done_b; obs_done[2] = done_c;
    if (mvalid)
      for (int v = 0; v < 3; v++) begin
        chk($sformatf("rd0_v%0d", v), obs_rd[v][31:0],  exp_rd(v, r0));
        chk($sformatf("rd1_v%0d", v), obs_rd[v][63:32], exp_rd(v, r1));
        chk($sformatf("busy_v%0d", v), 32'(obs_busy[v]), 32'(mbusy));
        chk($sformatf("done_v%0d", v), 32'(obs_done[v]), 32'(mdone));
      end
    if (r) busy_cnt = 0;
    else if (busy_a) busy_cnt++;
    if (done_a) done_cnt++;
    @(posedge clk);
    if (r) begin
      mbusy = 1'b1; mdone = 1'b0; mptr = 0; mvalid = 1'b1;
    end else if (mvalid) begin
      mdone = 1'b0;
      if (mbusy) begin
        for (int v = 0; v < 3; v++) mem[v][mptr] = (v == 2) ? 32'h0 : 32'(mptr);
        mptr++;
        if (mptr == 32) begin mbusy = 1'b0; mdone = 1'b1; end
      end else if (model_commit()) begin
        for (int v = 0; v < 3; v++) mem[v][wa] = after_write(v);
      end
    end
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, r0, r1);
  endtask

  initial begin
    // Clear sweep after a 3-cycle reset
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 5'd0, 5'd0);
    done_cnt = 0;
    repeat (32) idle(5'd7, 5'd31);
    idle(5'd7, 5'd31);
    chk("busy_cycles", 32'(busy_cnt), 32'd32);
    chk("sweep_rd7", obs_rd[0][31:0], 32'h7);
    chk("sweep_rd31", obs_rd[0][63:32], 32'h1F);
    chk("init0_rd7", obs_rd[2][31:0], 32'h0);
    idle(5'd0, 5'd0);
    chk("done_pulses", 32'(done_cnt), 32'd1);

    // Byte-enable write
    cyc(1'b0, 1'b1, 1'b0, 4'b1010, 5'd5, 32'hAABBCCDD, 5'd0, 5'd0);
    idle(5'd5, 5'd5);
    chk("be_write", obs_rd[0][31:0], 32'hAA00CC05);

    // Forwarding vs none
    cyc(1'b0, 1'b1, 1'b0, 4'hF, 5'd9, 32'h12345678, 5'd9, 5'd9);
    chk("byp_fwd", obs_rd[0][31:0], 32'h12345678);
    chk("nobyp_old", obs_rd[1][31:0], 32'h9);
    idle(5'd9, 5'd0);
    chk("nobyp_new", obs_rd[1][31:0], 32'h12345678);

    // Zero register
    cyc(1'b0, 1'b1, 1'b0, 4'hF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    chk("r0_same", obs_rd[0][31:0], 32'h0);
    idle(5'd0, 5'd0);
    chk("r0_next", obs_rd[0][31:0], 32'h0);

    // Freeze
    cyc(1'b0, 1'b1, 1'b1, 4'hF, 5'd3, 32'hDEADBEEF, 5'd3, 5'd3);
    chk("frz_same", obs_rd[0][31:0], 32'h3);
    idle(5'd3, 5'd0);
    chk("frz_next", obs_rd[0][31:0], 32'h3);

    // Reset mid-sweep with writes attempted while busy
    done_cnt = 0;
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 5'd0, 5'd0);
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 4'hF, 5'd2, 32'h55, 5'd2, 5'd2);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 4'hF, 5'd2, 32'h55, 5'd2, 5'd2);
    repeat (32) idle(5'd2, 5'd2);
    idle(5'd2, 5'd2);
    chk("restart_busy", 32'(busy_cnt), 32'd32);
    chk("restart_rd2", obs_rd[0][31:0], 32'h2);
    idle(5'd0, 5'd0);
    chk("restart_done", 32'(done_cnt), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a, r0, r1;
      a  = 5'($urandom);
      r0 = ($urandom_range(0, 1) == 1) ? a : 5'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom);
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0), 4'($urandom), a, $urandom, r0, r1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-write, two-read CPU register file. Sits in the decode stage of the single-cycle/pipelined datapath.
- Generalised width, depth and read-port count. Adds:
  - byte-enable writes;
  - optional same-cycle write-to-read forwarding;
  - a debug write-freeze;
  - a sequential post-reset clear sweep with a busy flag, replacing the simulation-only initial preload.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth NREGS = 2**ADDR_W.
- NRD, 2, number of read ports (1..4).
- ZERO_R0, 1, if 1, register 0 reads as 0 and writes to it are discarded.
- BYPASS, 1, if 1, a same-cycle write is forwarded to matching read ports.
- INIT_MODE, 1, clear-sweep value: 0 = all zero, 1 = register index (zero-extended).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset; starts the clear sweep.
- we  in  1  write enable.
- wfreeze  in  1  debug freeze; when 1, all writes are suppressed.
- wbe  in  DATA_W/8  byte enables for the write; bit k covers bits [8k+7:8k].
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- ra  in  NRD*ADDR_W  packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- rd  out  NRD*DATA_W  packed read data, combinational.
- busy  out  1  high while reset or clear sweep is in progress.
- sweep_done  out  1  single-cycle pulse when the sweep finishes.

Behaviour:
- Reset (sync, active-high): state=CLEAR, ptr=0, busy=1, sweep_done=0. The array is not written while rst=1.
- FSM states:
  - CLEAR (rst=0): write rf[ptr] = init(ptr), then ptr++.
  - When ptr == NREGS-1 is written: next state READY, sweep_done=1 for exactly that following cycle, busy=0 from that cycle.
  - Sweep therefore takes NREGS cycles after rst falls; busy is high for those NREGS cycles.
  - READY: normal operation. Stays in READY until rst.
- rst asserted mid-sweep restarts the sweep from ptr=0. rst asserted in READY re-enters CLEAR.
- Write commit (READY only): at the rising edge, if we && !wfreeze && wbe!=0 && !(ZERO_R0 && wa==0), then for each k with wbe[k]=1, rf[wa] byte k = wd byte k. Bytes with wbe[k]=0 keep their old value.
- Writes are ignored during CLEAR and while rst=1, regardless of we.
- Read port p (combinational, zero latency):
  - busy=1 -> 0.
  - ZERO_R0 && ra_p==0 -> 0.
  - BYPASS && write-commit condition true this cycle && ra_p==wa -> merged word: wd bytes where wbe=1, rf[wa] bytes where wbe=0.
  - otherwise rf[ra_p].
- BYPASS=0: a read of the address being written returns the old value until the next cycle.
- Forwarding never applies when wfreeze=1, when the write targets r0 with ZERO_R0=1, or during busy.
- Multiple read ports may hit the same address; each returns the same value independently.
- ZERO_R0=0: r0 is an ordinary register, cleared to init(0)=0 by the sweep.
- init(i) for INIT_MODE=1 is i zero-extended to DATA_W.
- No X on rd after the sweep; rd is 0 during busy.

Test Plan (DATA_W=32, ADDR_W=5, NRD=2, defaults unless noted):
- Clear sweep: rst high 3 cycles then low -> busy=1 for exactly 32 cycles, sweep_done pulses once on cycle 32; then ra0=7 -> rd0=0x00000007, ra1=31 -> rd1=0x0000001F. Repeat with INIT_MODE=0 -> rd0=0.
- Byte-enable write: rf[5]=0x00000005; we=1, wa=5, wd=0xAABBCCDD, wbe=4'b1010 -> next cycle ra0=5 reads 0xAA00CC05.
- Bypass: same cycle as we=1, wa=9, wd=0x12345678, wbe=4'hF, ra0=9 -> rd0=0x12345678 combinationally in that cycle. With BYPASS=0 -> rd0=0x00000009 that cycle, 0x12345678 the next.
- Zero register and freeze:
  - we=1, wa=0, wd=0xFFFFFFFF -> ra0=0 reads 0.
  - wfreeze=1, we=1, wa=3, wd=0xDEADBEEF -> ra0=3 still reads 0x00000003, and there is no forwarding.
- Reset mid-sweep and writes while busy: assert rst at sweep cycle 10 after writing we=1, wa=2, wd=0x55 during the sweep -> sweep restarts (busy for a further 32 cycles after rst falls), rf[2] ends 0x00000002, and sweep_done pulses only once at the final end.
